clb_config_loader: RTL and testbench
====================================

# clb_config_loader

Configuration loader for a daisy-chained row of CLBs. Accepts the configuration bitstream as `WORD_W`-bit words over a valid/ready handshake and serializes them onto the shared scan-chain inputs (`cfg_en`, `cfg_in`) of `NUM_CLB` CLBs wired in series. It shifts exactly `NUM_CLB*CONFIG_SIZE` bits and then reports completion. It holds the CLB fabric in reset until a complete load has finished.

## Interface

Parameters:

- `CONFIG_SIZE`, 37: configuration bits per CLB.
- `NUM_CLB`, 4: CLBs in the chain.
- `WORD_W`, 8: input word width.
- Derived: `TOTAL_BITS = NUM_CLB*CONFIG_SIZE` (148 by default).
- Derived: `NUM_WORDS = ceil(TOTAL_BITS/WORD_W)` (19 by default).

Ports:

- `cfg_clk` in 1: the single clock. Also drives the CLB chains.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: single-cycle request to begin a load.
- `abort` in 1: synchronous cancel of a load in progress.
- `in_data` in `WORD_W`: bitstream word. Bit 0 is shifted first.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: loader accepts a word this cycle.
- `cfg_en` out 1: shift enable to every CLB chain.
- `cfg_in` out 1: serial bit into the head of the first CLB.
- `busy` out 1: a load is in progress.
- `done` out 1: the last load completed successfully.
- `clb_reset` out 1: reset to the CLB fabric.
- `bit_count` out `$clog2(TOTAL_BITS+1)`: number of bits shifted in the current or last load.

## Operation

- States: IDLE, LOAD, SHIFT, DONE.
- **IDLE**
  - `start` moves the block to LOAD and clears `bit_count` to 0.
- **LOAD**
  - `in_ready`=1.
  - When `in_valid` and `in_ready` are both high, the block captures `in_data` into the shift register, clears the per-word bit counter, and goes to SHIFT.
  - Without `in_valid`, the block waits in LOAD indefinitely.
- **SHIFT**
  - Every cycle: `cfg_en`=1, `cfg_in`=`shreg[0]`, the shift register shifts right by 1, and `bit_count` increments.
  - When `bit_count` reaches `TOTAL_BITS`, the block goes to DONE. That cycle's bit is the last one shifted.
  - Otherwise, after `WORD_W` bits, the block returns to LOAD.
  - The final word contributes only `TOTAL_BITS mod WORD_W` bits (4 by default). Its upper bits are never shifted.
- **DONE**
  - `done`=1 and `clb_reset`=0.
  - `start` returns the block to LOAD, clears `done` and `bit_count`, and reasserts `clb_reset` in the same transition.
- Bit ordering: the first bit shifted ends in the deepest position, i.e. the last CLB's `configuration_word[CONFIG_SIZE-1]`.
- `busy` = (state is LOAD or SHIFT).
- `clb_reset` = 1 in every state except DONE.
- `start` while `busy` is ignored.
- `abort` while `busy` moves the block to IDLE:
  - `done`=0 and `clb_reset` stays 1.
  - `bit_count` holds the number of bits shifted so far.
  - The partially loaded chain is treated as invalid.
  - `abort` has priority over the word handshake and the shift in the same cycle. No shift occurs in the abort cycle.
- `abort` in IDLE or DONE has no effect.
- `start` and `abort` asserted together while idle: `start` wins.
- `in_valid` outside LOAD is ignored. No data is consumed.

## Timing

- Reset values (asynchronous, held while `reset`=1):
  - state IDLE.
  - `in_ready`=0, `cfg_en`=0, `cfg_in`=0.
  - `busy`=0, `done`=0, `clb_reset`=1.
  - `bit_count`=0.
  - shift register = 0.
- Reset mid-load: outputs take the reset values immediately. The chain contents are undefined.
- `cfg_en`, `cfg_in`, `in_ready`, `busy`, `done` and `clb_reset` are decoded from registers only. There is no combinational path from any input.
- Latency from `start` (sampled at edge t):
  - `in_ready`=1 in cycle t+1.
  - A word accepted at edge n shifts its bits in cycles n+1 … n+`WORD_W`.
  - LOAD is re-entered at n+`WORD_W`+1.
- With `in_valid` held high, each full word costs `WORD_W`+1 cycles. Default full load: 18×9 + 1 + 4 = 167 cycles from the first acceptance to the `done` rise.
- `done` rises in the cycle after the last `cfg_en`=1 cycle.

## Test plan

- **Full load**: `start`, then 19 words, `in_valid` held high, pattern `word k = k*0x11` → exactly 148 `cfg_en` cycles, `in_ready` accepts exactly 19 words, `done`=1, `clb_reset`=0, `bit_count`=148. Each CLB's `configuration_word` matches the reference serialization.
- **Backpressure**: `in_valid` low for 5 cycles between each word → same chain contents and 148 shift cycles. `cfg_en`=0 throughout every gap.
- **Abort**: `abort` after 3 bits of word 2 → next cycle IDLE, `busy`=0, `done`=0, `clb_reset`=1, `bit_count`=19, no further `cfg_en`.
- **Ignored start**: `start` pulsed during SHIFT → no restart, and the load completes with `bit_count`=148.
- **Last-word truncation and reload**: last word = 0xF5 → only 4 shifted bits, 0101 in order 1,0,1,0. A `start` from DONE drops `done` and raises `clb_reset` on the next cycle.
- **Async reset**: `reset` asserted mid-SHIFT, between clock edges → outputs take the reset values before the next edge. After release, a fresh `start` loads correctly.

Source files
------------

// File: rtl/clb_config_loader.sv
// ---------------------------------------------------------------------------
// clb_config_loader
//
// Streams a configuration bitstream into a daisy-chained row of CLBs.
// Words arrive over a valid/ready handshake and are serialized LSB first onto
// the shared scan-chain inputs. Exactly NUM_CLB*CONFIG_SIZE bits are shifted.
// After that the block reports completion and releases the CLB fabric from
// reset.
//
// Ports
//   cfg_clk   : single clock, also clocks the CLB scan chains
//   reset     : asynchronous active-high reset
//   start     : single-cycle request to begin a load (ignored while busy)
//   abort     : synchronous cancel of a load in progress
//   in_data   : bitstream word, bit 0 shifted first
//   in_valid  : in_data is valid
//   in_ready  : loader accepts a word this cycle
//   cfg_en    : shift enable to every CLB chain
//   cfg_in    : serial bit into the head of the first CLB
//   busy      : a load is in progress
//   done      : last load completed successfully
//   clb_reset : reset to the CLB fabric, released only after a full load
//   bit_count : bits shifted in the current or last load
// ---------------------------------------------------------------------------
module clb_config_loader #(
    parameter int CONFIG_SIZE = 37,
    parameter int NUM_CLB     = 4,
    parameter int WORD_W      = 8,
    localparam int TOTAL_BITS = NUM_CLB * CONFIG_SIZE,
    localparam int CNT_W      = $clog2(TOTAL_BITS + 1)
) (
    input  logic              cfg_clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              cfg_en,
    output logic              cfg_in,
    output logic              busy,
    output logic              done,
    output logic              clb_reset,
    output logic [CNT_W-1:0]  bit_count
);

    localparam int WB_W = $clog2(WORD_W + 1);

    // Counter values seen in the cycle that shifts the final bit of the whole
    // stream / of the current word; the transition happens on that edge.
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(TOTAL_BITS - 1);
    localparam logic [WB_W-1:0]  LAST_WBIT = WB_W'(WORD_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_q,   state_d;
    logic [WORD_W-1:0]   shreg_q,   shreg_d;
    logic [CNT_W-1:0]    bitCnt_q,  bitCnt_d;
    logic [WB_W-1:0]     wordBit_q, wordBit_d;

    // State, shift register and counters. Everything returns to its idle
    // value immediately on reset so the fabric is held in reset mid-load.
    always_ff @(posedge cfg_clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bitCnt_q  <= '0;
            wordBit_q <= '0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bitCnt_q  <= bitCnt_d;
            wordBit_q <= wordBit_d;
        end
    end

    // Next-state logic. Abort is checked first in LOAD and SHIFT so that an
    // abort cycle neither consumes a word nor advances the shift register or
    // the bit counter. The final word runs out of TOTAL_BITS before its
    // per-word count completes, so its upper bits are never shifted.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bitCnt_d  = bitCnt_q;
        wordBit_d = wordBit_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = LOAD;
                    bitCnt_d = '0;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (in_valid) begin
                    shreg_d   = in_data;
                    wordBit_d = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    shreg_d   = shreg_q >> 1;
                    bitCnt_d  = bitCnt_q + CNT_W'(1);
                    wordBit_d = wordBit_q + WB_W'(1);
                    if (bitCnt_q == LAST_BIT) begin
                        state_d = DONE;
                    end else if (wordBit_q == LAST_WBIT) begin
                        state_d = LOAD;
                    end
                end
            end
            DONE: begin
                if (start) begin
                    state_d  = LOAD;
                    bitCnt_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // All handshake and chain outputs are pure decodes of registers, so no
    // input reaches an output combinationally. cfg_in is gated to SHIFT so
    // leftover bits of a truncated last word never appear on the chain.
    assign in_ready  = (state_q == LOAD);
    assign cfg_en    = (state_q == SHIFT);
    assign cfg_in    = (state_q == SHIFT) & shreg_q[0];
    assign busy      = (state_q == LOAD) | (state_q == SHIFT);
    assign done      = (state_q == DONE);
    assign clb_reset = (state_q != DONE);
    assign bit_count = bitCnt_q;

endmodule

// File: tb/tb_clb_config_loader.sv
// ---------------------------------------------------------------------------
// tb_clb_config_loader
//
// Directed bench for clb_config_loader. A behavioural CLB chain is built from
// the cfg_en/cfg_in outputs and compared against the expected serialization
// of the words sent. Each scenario lives in its own test_* task.
// ---------------------------------------------------------------------------
module tb_clb_config_loader;

    localparam int CONFIG_SIZE = 37;
    localparam int NUM_CLB     = 4;
    localparam int WORD_W      = 8;
    localparam int TOTAL_BITS  = 148;
    localparam int NUM_WORDS   = 19;
    localparam int LOG_SIZE    = 2048;

    logic        cfg_clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        cfg_en;
    logic        cfg_in;
    logic        busy;
    logic        done;
    logic        clb_reset;
    logic [7:0]  bit_count;

    int checks = 0;
    int errors = 0;

    logic [7:0]            tbWords [0:NUM_WORDS-1];
    logic [TOTAL_BITS-1:0] chain;
    logic                  bitLog [0:LOG_SIZE-1];
    int                    acceptCyc [0:255];
    int                    enCount  = 0;
    int                    accCount = 0;
    int                    cyc      = 0;
    int                    gapEn    = 0;

    clb_config_loader #(
        .CONFIG_SIZE(CONFIG_SIZE),
        .NUM_CLB    (NUM_CLB),
        .WORD_W     (WORD_W)
    ) dut (
        .cfg_clk  (cfg_clk),
        .reset    (reset),
        .start    (start),
        .abort    (abort),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .cfg_en   (cfg_en),
        .cfg_in   (cfg_in),
        .busy     (busy),
        .done     (done),
        .clb_reset(clb_reset),
        .bit_count(bit_count)
    );

    always #5 cfg_clk = ~cfg_clk;

    // Behavioural CLB row: every enabled edge pushes cfg_in into the head, so
    // the first bit shifted ends up at index TOTAL_BITS-1 (deepest position).
    // CLB k owns chain[k*CONFIG_SIZE +: CONFIG_SIZE].
    always @(posedge cfg_clk) begin
        cyc++;
        if (cfg_en === 1'b1) begin
            chain = {chain[TOTAL_BITS-2:0], cfg_in};
            bitLog[enCount % LOG_SIZE] = cfg_in;
            enCount++;
        end
        if (in_valid === 1'b1 && in_ready === 1'b1) begin
            acceptCyc[accCount % 256] = cyc;
            accCount++;
        end
    end

    // Global guard so a wedged design still ends the run.
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [TOTAL_BITS-1:0] expChain();
        logic [TOTAL_BITS-1:0] e;
        logic [7:0]            w;
        e = '0;
        for (int i = 0; i < TOTAL_BITS; i++) begin
            w = tbWords[i / 8];
            e[TOTAL_BITS-1-i] = w[i % 8];
        end
        return e;
    endfunction

    task automatic setPattern();
        for (int k = 0; k < NUM_WORDS; k++) tbWords[k] = 8'((k * 17) & 8'hFF);
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(negedge cfg_clk);
        start = 1'b0;
    endtask

    task automatic waitReady(output bit ok);
        int t;
        t = 0;
        while (in_ready !== 1'b1 && t < 100) begin
            @(negedge cfg_clk);
            t++;
        end
        ok = (in_ready === 1'b1);
    endtask

    // Sends words first..last. With gap > 0, in_valid is held low for gap
    // cycles after each return to LOAD, and cfg_en is sampled during the gap.
    task automatic sendWords(input int first, input int last, input int gap);
        bit ok;
        for (int k = first; k <= last; k++) begin
            if (gap > 0) begin
                in_valid = 1'b0;
                waitReady(ok);
                repeat (gap) begin
                    @(negedge cfg_clk);
                    if (cfg_en !== 1'b0) gapEn++;
                end
            end
            in_valid = 1'b1;
            in_data  = tbWords[k];
            waitReady(ok);
            if (!ok) begin
                checks++;
                errors++;
                $display("[TB] FAIL word_accept_timeout: word %0d in_ready=%b, required 1", k, in_ready);
                return;
            end
            @(negedge cfg_clk);
            if (gap > 0) in_valid = 1'b0;
        end
    endtask

    task automatic waitDone(output int seenCyc);
        int t;
        t = 0;
        while (done !== 1'b1 && t < 400) begin
            @(negedge cfg_clk);
            t++;
        end
        seenCyc = cyc;
        if (done !== 1'b1) begin
            checks++;
            errors++;
            $display("[TB] FAIL done_timeout: done=%b, required 1", done);
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(negedge cfg_clk);
        checks++;
        if ({in_ready, cfg_en, cfg_in, busy, done, clb_reset, bit_count} !== {6'b000001, 8'd0}) begin
            errors++;
            $display("[TB] FAIL reset_values: got %b, required %b",
                     {in_ready, cfg_en, cfg_in, busy, done, clb_reset, bit_count}, {6'b000001, 8'd0});
        end
        reset = 1'b0;
        @(negedge cfg_clk);
        // start and abort together while idle: start must win
        start = 1'b1;
        abort = 1'b1;
        @(negedge cfg_clk);
        start = 1'b0;
        abort = 1'b0;
        checks++;
        if ({busy, in_ready} !== 2'b11) begin
            errors++;
            $display("[TB] FAIL start_beats_abort: busy,in_ready=%b, required 11", {busy, in_ready});
        end
        // abort in LOAD returns to IDLE
        abort = 1'b1;
        @(negedge cfg_clk);
        abort = 1'b0;
        checks++;
        if ({busy, in_ready, done, clb_reset} !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL abort_in_load: busy,in_ready,done,clb_reset=%b, required 0001",
                     {busy, in_ready, done, clb_reset});
        end
    endtask

    task automatic test_full_load();
        int baseEn, baseAcc, doneCyc;
        logic [TOTAL_BITS-1:0] e;
        setPattern();
        baseEn  = enCount;
        baseAcc = accCount;
        pulseStart();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ready_after_start: in_ready=%b, required 1", in_ready);
        end
        sendWords(0, NUM_WORDS - 1, 0);
        waitDone(doneCyc);
        in_valid = 1'b0;
        checks++;
        if (enCount - baseEn !== TOTAL_BITS) begin
            errors++;
            $display("[TB] FAIL full_shift_cycles: got %0d, required %0d", enCount - baseEn, TOTAL_BITS);
        end
        checks++;
        if (accCount - baseAcc !== NUM_WORDS) begin
            errors++;
            $display("[TB] FAIL full_words_accepted: got %0d, required %0d", accCount - baseAcc, NUM_WORDS);
        end
        checks++;
        if ({done, clb_reset, busy, bit_count} !== {3'b100, 8'd148}) begin
            errors++;
            $display("[TB] FAIL full_status: done,clb_reset,busy,bit_count=%b,%b,%b,%0d, required 1,0,0,148",
                     done, clb_reset, busy, bit_count);
        end
        // First acceptance at edge n; done rises in cycle n+167, i.e. it is
        // first seen after edge n+166.
        checks++;
        if (doneCyc - acceptCyc[baseAcc % 256] !== 166) begin
            errors++;
            $display("[TB] FAIL full_latency: edges from first accept to done=%0d, required 166",
                     doneCyc - acceptCyc[baseAcc % 256]);
        end
        e = expChain();
        for (int k = 0; k < NUM_CLB; k++) begin
            checks++;
            if (chain[k*CONFIG_SIZE +: CONFIG_SIZE] !== e[k*CONFIG_SIZE +: CONFIG_SIZE]) begin
                errors++;
                $display("[TB] FAIL full_clb%0d_config: got %h, required %h", k,
                         chain[k*CONFIG_SIZE +: CONFIG_SIZE], e[k*CONFIG_SIZE +: CONFIG_SIZE]);
            end
        end
    endtask

    task automatic test_backpressure();
        int baseEn, doneCyc;
        logic [TOTAL_BITS-1:0] e;
        setPattern();
        baseEn = enCount;
        gapEn  = 0;
        pulseStart();
        sendWords(0, NUM_WORDS - 1, 5);
        waitDone(doneCyc);
        checks++;
        if (enCount - baseEn !== TOTAL_BITS) begin
            errors++;
            $display("[TB] FAIL bp_shift_cycles: got %0d, required %0d", enCount - baseEn, TOTAL_BITS);
        end
        checks++;
        if (gapEn !== 0) begin
            errors++;
            $display("[TB] FAIL bp_gap_cfg_en: cfg_en high in %0d gap cycles, required 0", gapEn);
        end
        checks++;
        if ({done, bit_count} !== {1'b1, 8'd148}) begin
            errors++;
            $display("[TB] FAIL bp_status: done=%b bit_count=%0d, required 1,148", done, bit_count);
        end
        e = expChain();
        for (int k = 0; k < NUM_CLB; k++) begin
            checks++;
            if (chain[k*CONFIG_SIZE +: CONFIG_SIZE] !== e[k*CONFIG_SIZE +: CONFIG_SIZE]) begin
                errors++;
                $display("[TB] FAIL bp_clb%0d_config: got %h, required %h", k,
                         chain[k*CONFIG_SIZE +: CONFIG_SIZE], e[k*CONFIG_SIZE +: CONFIG_SIZE]);
            end
        end
    endtask

    task automatic test_abort();
        int baseEn;
        setPattern();
        pulseStart();
        sendWords(0, 2, 0);
        in_valid = 1'b0;
        repeat (3) @(negedge cfg_clk);
        abort = 1'b1;
        @(negedge cfg_clk);
        abort = 1'b0;
        checks++;
        if ({busy, done, clb_reset, in_ready, cfg_en} !== 5'b00100) begin
            errors++;
            $display("[TB] FAIL abort_status: busy,done,clb_reset,in_ready,cfg_en=%b, required 00100",
                     {busy, done, clb_reset, in_ready, cfg_en});
        end
        checks++;
        if (bit_count !== 8'd19) begin
            errors++;
            $display("[TB] FAIL abort_bit_count: got %0d, required 19", bit_count);
        end
        baseEn   = enCount;
        in_valid = 1'b1;
        repeat (20) @(negedge cfg_clk);
        in_valid = 1'b0;
        checks++;
        if (enCount !== baseEn || bit_count !== 8'd19) begin
            errors++;
            $display("[TB] FAIL abort_quiet: extra cfg_en=%0d bit_count=%0d, required 0,19",
                     enCount - baseEn, bit_count);
        end
    endtask

    task automatic test_ignored_start();
        int baseEn, doneCyc;
        logic [TOTAL_BITS-1:0] e;
        setPattern();
        baseEn = enCount;
        pulseStart();
        sendWords(0, 0, 0);
        @(negedge cfg_clk);
        pulseStart();
        checks++;
        if ({busy, in_ready, bit_count} !== {2'b10, 8'd2}) begin
            errors++;
            $display("[TB] FAIL start_in_shift: busy=%b in_ready=%b bit_count=%0d, required 1,0,2",
                     busy, in_ready, bit_count);
        end
        sendWords(1, NUM_WORDS - 1, 0);
        waitDone(doneCyc);
        in_valid = 1'b0;
        checks++;
        if ({done, bit_count} !== {1'b1, 8'd148} || enCount - baseEn !== TOTAL_BITS) begin
            errors++;
            $display("[TB] FAIL ignored_start_done: done=%b bit_count=%0d shifts=%0d, required 1,148,148",
                     done, bit_count, enCount - baseEn);
        end
        e = expChain();
        for (int k = 0; k < NUM_CLB; k++) begin
            checks++;
            if (chain[k*CONFIG_SIZE +: CONFIG_SIZE] !== e[k*CONFIG_SIZE +: CONFIG_SIZE]) begin
                errors++;
                $display("[TB] FAIL ignored_start_clb%0d: got %h, required %h", k,
                         chain[k*CONFIG_SIZE +: CONFIG_SIZE], e[k*CONFIG_SIZE +: CONFIG_SIZE]);
            end
        end
    endtask

    task automatic test_truncation();
        int baseEn, doneCyc;
        logic [3:0] seq;
        logic [TOTAL_BITS-1:0] e;
        setPattern();
        tbWords[NUM_WORDS-1] = 8'hF5;
        baseEn = enCount;
        pulseStart();
        sendWords(0, NUM_WORDS - 1, 0);
        waitDone(doneCyc);
        in_valid = 1'b0;
        // 0xF5: bits 0..3 are 1,0,1,0; first-shifted bit placed in the MSB
        seq = {bitLog[(baseEn + 144) % LOG_SIZE], bitLog[(baseEn + 145) % LOG_SIZE],
               bitLog[(baseEn + 146) % LOG_SIZE], bitLog[(baseEn + 147) % LOG_SIZE]};
        checks++;
        if (seq !== 4'b1010 || enCount - baseEn !== TOTAL_BITS) begin
            errors++;
            $display("[TB] FAIL trunc_last_bits: seq=%b shifts=%0d, required 1010,148",
                     seq, enCount - baseEn);
        end
        e = expChain();
        checks++;
        if (chain !== e) begin
            errors++;
            $display("[TB] FAIL trunc_chain: got %h, required %h", chain, e);
        end
        checks++;
        if ({done, clb_reset} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL trunc_done: done,clb_reset=%b, required 10", {done, clb_reset});
        end
        pulseStart();
        checks++;
        if ({done, clb_reset, in_ready, bit_count} !== {3'b011, 8'd0}) begin
            errors++;
            $display("[TB] FAIL reload_from_done: done,clb_reset,in_ready=%b bit_count=%0d, required 011,0",
                     {done, clb_reset, in_ready}, bit_count);
        end
        abort = 1'b1;
        @(negedge cfg_clk);
        abort = 1'b0;
    endtask

    task automatic test_async_reset();
        int doneCyc;
        logic [TOTAL_BITS-1:0] e;
        setPattern();
        pulseStart();
        sendWords(0, 1, 0);
        in_valid = 1'b0;
        repeat (3) @(negedge cfg_clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({in_ready, cfg_en, cfg_in, busy, done, clb_reset, bit_count} !== {6'b000001, 8'd0}) begin
            errors++;
            $display("[TB] FAIL async_reset_values: got %b, required %b",
                     {in_ready, cfg_en, cfg_in, busy, done, clb_reset, bit_count}, {6'b000001, 8'd0});
        end
        @(negedge cfg_clk);
        reset = 1'b0;
        @(negedge cfg_clk);
        pulseStart();
        sendWords(0, NUM_WORDS - 1, 0);
        waitDone(doneCyc);
        in_valid = 1'b0;
        checks++;
        if ({done, clb_reset, bit_count} !== {2'b10, 8'd148}) begin
            errors++;
            $display("[TB] FAIL post_reset_load: done,clb_reset=%b bit_count=%0d, required 10,148",
                     {done, clb_reset}, bit_count);
        end
        e = expChain();
        for (int k = 0; k < NUM_CLB; k++) begin
            checks++;
            if (chain[k*CONFIG_SIZE +: CONFIG_SIZE] !== e[k*CONFIG_SIZE +: CONFIG_SIZE]) begin
                errors++;
                $display("[TB] FAIL post_reset_clb%0d: got %h, required %h", k,
                         chain[k*CONFIG_SIZE +: CONFIG_SIZE], e[k*CONFIG_SIZE +: CONFIG_SIZE]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_backpressure();
        test_abort();
        test_ignored_start();
        test_truncation();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
